// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI mode-0 slave
//
// Purpose : SPI mode constants, slave FSM state encoding, and the helper
//           that builds the all-ones idle transmit word for any width.
// Ports   : none (package)

package spi_pkg;

  // Mode 0: SCLK idles low, data sampled on rising edge, shifted on falling.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Slave FSM state encoding.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // All-ones word of the requested width; the caller truncates to its width.
  function automatic logic [63:0] tx_default_word(input int width);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        w[i] = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage input synchroniser with edge pulses
//
// Purpose : Brings an asynchronous pin into the clk domain and reports
//           single-clk rise/fall pulses by comparing the synchronised level
//           against a one-clk-delayed copy.
// Ports   : clk, rst (async, active-low)
//           i_d      - asynchronous input pin
//           o_level  - synchronised level
//           o_rise   - one-clk pulse on synchronised 0->1
//           o_fall   - one-clk pulse on synchronised 1->0

module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave endpoint with TX holding register
//
// Purpose : Oversamples SCLK/MOSI/CS, deserialises MOSI into rx_data words
//           and serialises words from a one-deep holding register onto MISO.
// Ports   : clk, rst (async, active-low)
//           SCLK, MOSI, CS      - SPI pins from the master (CS active-low)
//           MISO                - serial data to the master
//           tx_data/tx_valid/tx_ready - holding register load handshake
//           rx_data/rx_valid    - received word and its one-clk strobe
//           busy                - frame in progress
//           tx_underrun         - idle word was shifted out for a word
//           frame_err           - CS rose part way through a word

module spi_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = DATA_WIDTH'(tx_default_word(DATA_WIDTH)),
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  CS,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Conditioned pins
  logic w_sclk_lvl_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_n;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .i_d     (SCLK),
    .o_level (w_sclk_lvl_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // CS resets high so leaving reset never looks like a frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .i_d     (CS),
    .o_level (w_cs_n),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .i_d     (MOSI),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  // State
  logic [0:0]            r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_rx_shift;  // bits received so far in this word
  logic [DATA_WIDTH-2:0] r_tx_shift;  // bits still to send after the one on MISO
  logic                  r_miso;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic                  r_frame_err;

  logic                  w_active;
  logic                  w_word_done;
  logic                  w_load;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_load_word;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_active    = (r_state == ST_ACTIVE);
  assign w_word_done = w_active & w_sclk_rise & (r_bit_cnt == LAST_BIT);
  // A CS rise wins over a coincident SCLK fall, so no word is fetched for a
  // frame that is ending.
  assign w_load      = (~w_active & w_cs_fall)
                     | (w_active & ~w_cs_rise & w_sclk_fall & (r_bit_cnt == '0));
  assign w_accept    = tx_valid & ~r_hold_full;
  assign w_load_word = r_hold_full ? r_hold_data : TX_DEFAULT;
  assign w_rx_next   = {r_rx_shift, w_mosi};

  // Holding register. A load in the same clk as an accept reads the old
  // (registered) contents, and the newly accepted word stays held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_data <= tx_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_underrun  <= w_load & ~r_hold_full;

      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_bit_cnt  <= '0;
            r_tx_shift <= w_load_word[DATA_WIDTH-2:0];
            r_miso     <= w_load_word[DATA_WIDTH-1];
          end
        end

        ST_ACTIVE: begin
          if (w_sclk_rise) begin
            r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
            if (w_word_done) begin
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end

          if (w_cs_rise) begin
            // A word completing on this same clk is not a framing error.
            r_state   <= ST_IDLE;
            r_miso    <= 1'b0;
            r_bit_cnt <= '0;
            if ((r_bit_cnt != '0) && !w_word_done) begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (r_bit_cnt == '0) begin
              r_tx_shift <= w_load_word[DATA_WIDTH-2:0];
              r_miso     <= w_load_word[DATA_WIDTH-1];
            end else begin
              r_miso     <= r_tx_shift[DATA_WIDTH-2];
              r_tx_shift <= r_tx_shift << 1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  assign MISO        = r_miso;
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = w_active & ~w_cs_n;
  assign tx_underrun = r_underrun;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave

module tb_spi_slave;

  localparam int HALF = 4;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       CS = 1'b1;
  logic       MISO;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;
  logic       frame_err;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .CS          (CS),
    .MISO        (MISO),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cnt_rxv = 0;
  int         cnt_und = 0;
  int         cnt_ferr = 0;
  int         cnt_acc = 0;
  logic [7:0] exp_rx[$];

  // Scoreboard and event counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      cnt_rxv++;
      n_chk++;
      if (exp_rx.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_rx.pop_front();
        if (rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_word: got 0x%0h, expected 0x%0h", rx_data, e);
        end
      end
    end
    if (tx_underrun) cnt_und++;
    if (frame_err) cnt_ferr++;
    if (rst && tx_valid && tx_ready) cnt_acc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_tx_timeout: got tx_ready=0, expected 1");
    end else begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  // One mode-0 bit; on the frame's last bit CS rises together with SCLK fall.
  task automatic spi_bit(input logic mo, output logic mi, input bit end_frame);
    MOSI = mo;
    wait_clk(HALF);
    SCLK = 1'b1;
    mi = MISO;
    wait_clk(HALF);
    SCLK = 1'b0;
    if (end_frame) CS = 1'b1;
  endtask

  task automatic spi_frame(input int nw, input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    for (int w = nw - 1; w >= 0; w--) exp_rx.push_back(mo[w*8 +: 8]);
    CS = 1'b0;
    wait_clk(6);
    chk("busy_in_frame", busy, 1);
    for (int i = nw * 8 - 1; i >= 0; i--) begin
      logic b;
      spi_bit(mo[i], b, i == 0);
      mi[i] = b;
    end
    wait_clk(6);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, MISO, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_tx_underrun"}, tx_underrun, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    bit         preload;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[3];
    logic [15:0] mi;
    int          r0, u0, f0, a0;
    logic        b;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'h3C, 0};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 8'hFF, 1};
    vecs[2] = '{8'hF0, 8'h0F, 1'b1, 8'h0F, 0};

    wait_clk(3);
    chk_reset_outputs("reset");
    rst = 1'b1;
    wait_clk(4);

    // Single-word frames from the table.
    for (int k = 0; k < 3; k++) begin
      r0 = cnt_rxv;
      u0 = cnt_und;
      if (vecs[k].preload) push_tx(vecs[k].tx);
      spi_frame(1, {8'h00, vecs[k].mosi}, mi);
      chk($sformatf("v%0d_miso_word", k), mi[7:0], vecs[k].exp_miso);
      chk($sformatf("v%0d_underruns", k), cnt_und - u0, vecs[k].exp_und);
      chk($sformatf("v%0d_rx_pulses", k), cnt_rxv - r0, 1);
      chk($sformatf("v%0d_rx_data", k), rx_data, vecs[k].mosi);
      chk($sformatf("v%0d_tx_ready", k), tx_ready, 1);
      chk($sformatf("v%0d_busy_after", k), busy, 0);
    end

    // Two-word frame, second TX word supplied after the first is loaded.
    r0 = cnt_rxv; u0 = cnt_und; f0 = cnt_ferr;
    push_tx(8'hAB);
    fork
      spi_frame(2, 16'h1234, mi);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (busy) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          n_chk++;
          n_fail++;
          $display("FAIL busy_timeout: got busy=0, expected 1");
        end else begin
          push_tx(8'hCD);
        end
      end
    join
    chk("two_word_miso", mi, 16'hABCD);
    chk("two_word_rx_pulses", cnt_rxv - r0, 2);
    chk("two_word_frame_err", cnt_ferr - f0, 0);
    chk("two_word_underruns", cnt_und - u0, 0);

    // Aborted word: 3 SCLK pulses then CS rises.
    r0 = cnt_rxv; f0 = cnt_ferr;
    CS = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, b, 1'b0);
    wait_clk(HALF);
    CS = 1'b1;
    wait_clk(8);
    chk("abort_frame_err", cnt_ferr - f0, 1);
    chk("abort_rx_pulses", cnt_rxv - r0, 0);
    chk("abort_rx_data", rx_data, 8'h34);
    chk("abort_busy", busy, 0);
    spi_frame(1, 16'h005A, mi);
    chk("after_abort_rx_data", rx_data, 8'h5A);
    chk("after_abort_rx_pulses", cnt_rxv - r0, 1);
    chk("after_abort_frame_err", cnt_ferr - f0, 1);

    // CS rises together with the final SCLK rise: word completes, no error.
    r0 = cnt_rxv; f0 = cnt_ferr;
    exp_rx.push_back(8'h96);
    CS = 1'b0;
    wait_clk(6);
    for (int i = 7; i >= 1; i--) spi_bit(i == 7 || i == 4 || i == 2 || i == 1, b, 1'b0);
    MOSI = 1'b0;
    wait_clk(HALF);
    SCLK = 1'b1;
    CS = 1'b1;
    wait_clk(HALF);
    SCLK = 1'b0;
    wait_clk(6);
    chk("cs_last_rise_rx_pulses", cnt_rxv - r0, 1);
    chk("cs_last_rise_frame_err", cnt_ferr - f0, 0);
    chk("cs_last_rise_rx_data", rx_data, 8'h96);
    chk("cs_last_rise_miso", MISO, 0);

    // Reset mid-frame with a word sitting in the holding register.
    f0 = cnt_ferr;
    CS = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b1, b, 1'b0);
      if (i == 0) push_tx(8'h99);
    end
    wait_clk(2);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    CS = 1'b1;
    SCLK = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(4);
    chk("midreset_frame_err", cnt_ferr - f0, 0);
    r0 = cnt_rxv;
    spi_frame(1, 16'h00C3, mi);
    chk("post_reset_rx_data", rx_data, 8'hC3);
    chk("post_reset_rx_pulses", cnt_rxv - r0, 1);
    chk("post_reset_miso", mi[7:0], 8'hFF);

    // tx_valid held high across idle and two word loads.
    a0 = cnt_acc; u0 = cnt_und;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    wait_clk(5);
    spi_frame(2, 16'h2468, mi);
    tx_valid = 1'b0;
    wait_clk(2);
    chk("held_valid_accepts", cnt_acc - a0, 3);
    chk("held_valid_miso", mi, 16'h7777);
    chk("held_valid_underruns", cnt_und - u0, 0);
    chk("held_valid_tx_ready", tx_ready, 0);
    spi_frame(1, 16'h0011, mi);
    chk("drain_miso", mi[7:0], 8'h77);
    chk("drain_tx_ready", tx_ready, 1);
    chk("drain_accepts", cnt_acc - a0, 3);
    chk("scoreboard_empty", exp_rx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
